// File: rtl/key_event.sv
// Button event decoder: press, release, short-press, long-press and optional auto-repeat pulses.
// Define KEY_REPEAT_EN to enable the auto-repeat counter in the LONG state.
module key_event #(
    parameter int unsigned LONG_TICKS   = 100,
    parameter int unsigned REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic input_btn,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Counter is cleared on every state entry so it stays below the threshold and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            held          <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (input_btn) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release takes priority over reaching the long threshold on the same edge.
                    if (!input_btn) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LONG: begin
                    if (!input_btn) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt == REPEAT_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

`ifndef KEY_REPEAT_EN
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: per-cycle scoreboard plus table-driven press sequences.
module tb_key_event;

    localparam int unsigned LT = 100;
    localparam int unsigned RT = 20;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn = 1'b0;
    logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

    always #5 clk = ~clk;

    key_event #(.LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_btn     (btn),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [5:0] exp_q[$];

    // Reference model state: 0 idle, 1 pressed, 2 long
    int m_st = 0;
    int m_age = 0;
    int m_rep = 0;

    int n_press, n_rel, n_short, n_long, n_rep;
    int press_cyc, long_cyc;
    int rep_cyc[$];

    typedef struct {
        int ones;
        int zeros;
        int exp_long;
        int exp_short;
        int exp_rep;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [5:0] outs();
        return {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bit order {press, release, short, long, repeat, held}; age counts edges since the press edge.
    task automatic model_step(input logic b, output logic [5:0] e);
        e = '0;
        case (m_st)
            0: if (b) begin
                e[5] = 1'b1; e[0] = 1'b1; m_st = 1; m_age = 0;
            end
            1: if (!b) begin
                e[4] = 1'b1; e[3] = 1'b1; m_st = 0;
            end else begin
                m_age++;
                e[0] = 1'b1;
                if (m_age == LT) begin
                    e[2] = 1'b1; m_st = 2; m_rep = 0;
                end
            end
            default: if (!b) begin
                e[4] = 1'b1; m_st = 0;
            end else begin
                e[0] = 1'b1;
                if (REP_ON) begin
                    m_rep++;
                    if (m_rep == RT) begin
                        e[1] = 1'b1; m_rep = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic clear_tally();
        n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0;
        press_cyc = -1; long_cyc = -1;
        rep_cyc.delete();
    endtask

    // Drive btn at the falling edge, compare at the next falling edge.
    task automatic cycle(input logic b);
        logic [5:0] e, a;
        btn = b;
        if (rst_n) model_step(b, e);
        else begin
            e = '0; m_st = 0; m_age = 0; m_rep = 0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        a = outs();
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d btn=%b: got %b expected %b", cyc, b, a, e);
        end
        if (a[5]) begin n_press++; press_cyc = cyc; end
        if (a[4]) n_rel++;
        if (a[3]) n_short++;
        if (a[2]) begin n_long++; long_cyc = cyc; end
        if (a[1]) begin n_rep++; rep_cyc.push_back(cyc); end
    endtask

    initial begin
        int start;
        tbl[0] = '{5,   3, 0, 1, 0};
        tbl[1] = '{1,   2, 0, 1, 0};
        tbl[2] = '{100, 3, 0, 1, 0};
        tbl[3] = '{101, 3, 1, 0, 0};
        tbl[4] = '{150, 3, 1, 0, 2};
        tbl[5] = '{170, 3, 1, 0, 3};

        #2 rst_n = 1'b0;
        #1 check("reset_outputs", int'(outs()), 0);
        @(negedge clk);
        cycle(1'b0);
        rst_n = 1'b1;
        cycle(1'b0);

        foreach (tbl[k]) begin
            clear_tally();
            start = cyc;
            for (int i = 0; i < tbl[k].ones; i++) cycle(1'b1);
            for (int i = 0; i < tbl[k].zeros; i++) cycle(1'b0);
            check($sformatf("v%0d_press_count", k), n_press, 1);
            check($sformatf("v%0d_press_latency", k), press_cyc - start, 1);
            check($sformatf("v%0d_release_count", k), n_rel, 1);
            check($sformatf("v%0d_short_count", k), n_short, tbl[k].exp_short);
            check($sformatf("v%0d_long_count", k), n_long, tbl[k].exp_long);
            check($sformatf("v%0d_repeat_count", k), n_rep, REP_ON ? tbl[k].exp_rep : 0);
            if (tbl[k].exp_long != 0)
                check($sformatf("v%0d_long_delay", k), long_cyc - press_cyc, int'(LT));
            for (int r = 0; r < rep_cyc.size(); r++)
                check($sformatf("v%0d_repeat%0d_delay", k, r), rep_cyc[r] - long_cyc, int'(RT) * (r + 1));
        end

        // One-cycle toggling: every press is released as a short press.
        clear_tally();
        for (int i = 0; i < 10; i++) cycle((i % 2) == 0);
        cycle(1'b0);
        check("toggle_press_count", n_press, 5);
        check("toggle_release_count", n_rel, 5);
        check("toggle_short_count", n_short, 5);
        check("toggle_long_count", n_long, 0);

        // Asynchronous reset while in LONG, button kept pressed through reset.
        clear_tally();
        for (int i = 0; i < 120; i++) cycle(1'b1);
        check("pre_reset_long", n_long, 1);
        check("pre_reset_held", int'(held), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", int'(outs()), 0);
        clear_tally();
        @(negedge clk);
        cycle(1'b1);
        cycle(1'b1);
        rst_n = 1'b1;
        cycle(1'b1);
        check("post_reset_press", n_press, 1);
        check("post_reset_no_release", n_rel, 0);
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        check("post_reset_short", n_short, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_TICKS, default 100, sets the long-press threshold in clk cycles (1 s at 100 Hz); legal range 2..255.
REQ-002 Parameter REPEAT_TICKS, default 20, sets the auto-repeat period in clk cycles; legal range 1..255.
REQ-003 Port clk  input  1  system clock (100 Hz), all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port input_btn  input  1  debounced button level, 1 = pressed, already synchronous to clk.
REQ-006 Port press_pulse  output  1  one-cycle pulse on accepted press.
REQ-007 Port release_pulse  output  1  one-cycle pulse on every release.
REQ-008 Port short_pulse  output  1  one-cycle pulse on release before the long threshold.
REQ-009 Port long_pulse  output  1  one-cycle pulse when the long threshold is reached.
REQ-010 Port repeat_pulse  output  1  one-cycle auto-repeat pulse while long-held.
REQ-011 Port held  output  1  level, high while the FSM is in PRESSED or LONG.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, PRESSED, LONG; all outputs registered, no combinational path from input_btn to any output.
REQ-013 IDLE -> PRESSED on an edge sampling input_btn=1; press_pulse=1 and held=1 during the following cycle; hold counter cleared to 0.
REQ-014 In PRESSED, the 8-bit hold counter SHALL increment once per cycle while input_btn=1.
REQ-015 PRESSED -> LONG when the counter reaches LONG_TICKS-1 with input_btn=1, so long_pulse occurs exactly LONG_TICKS cycles after press_pulse; counter cleared on entry.
REQ-016 PRESSED -> IDLE on an edge sampling input_btn=0; release_pulse=1 and short_pulse=1 in the same following cycle; held=0.
REQ-017 LONG -> IDLE on an edge sampling input_btn=0; release_pulse=1, short_pulse=0.
REQ-018 Simultaneous events: if input_btn=0 is sampled on the edge at which the long threshold would be reached, release wins (short_pulse, release_pulse; no long_pulse).
REQ-019 A new press SHALL be accepted on the first edge after returning to IDLE; the minimum press-to-press spacing is 2 cycles.
REQ-020 Each pulse output SHALL be high for exactly one cycle per event; at most one of press/long/repeat/release is high in any cycle, except short_pulse accompanying release_pulse.
REQ-021 The counter SHALL never wrap: it is cleared on every state entry and bounded by the parameter range.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, counter=0 and all outputs=0, regardless of clk.
REQ-023 Reset asserted mid-press SHALL emit no release_pulse; after deassertion with input_btn held at 1, a fresh press_pulse SHALL follow on the first clk edge.

Configuration
REQ-024 Macro KEY_REPEAT_EN defined: in LONG, repeat_pulse fires every REPEAT_TICKS cycles while input_btn=1, first one REPEAT_TICKS cycles after long_pulse; the counter reloads to 0 on each repeat.
REQ-025 Macro KEY_REPEAT_EN undefined: repeat_pulse is tied to 0, the LONG counter is not implemented, and all other behaviour is unchanged.

Verification
REQ-026 Reset, input_btn=1 for 5 cycles then 0 -> press_pulse at cycle 1, short_pulse and release_pulse together 1 cycle after the 0 is sampled, no long_pulse.
REQ-027 Defaults, input_btn=1 for 150 cycles -> long_pulse exactly 100 cycles after press_pulse; on release, release_pulse=1 and short_pulse=0.
REQ-028 KEY_REPEAT_EN, defaults, hold 170 cycles -> repeat_pulse at 20, 40 and 60 cycles after long_pulse; with the macro undefined, repeat_pulse stays 0.
REQ-029 Release on the threshold edge (input_btn=1 for exactly 99 cycles after press_pulse) -> short_pulse and release_pulse, long_pulse never asserted.
REQ-030 rst_n pulled low between clk edges during LONG -> all outputs 0 immediately; btn still 1 at release of reset -> press_pulse on the next edge.
REQ-031 1/0 toggling of input_btn every cycle for 10 cycles -> alternating press/release-with-short pulses, each exactly one cycle, held following the FSM state.
